// File: rtl/is_array_feeder.sv
// Edge feeder for an input-stationary PE column: shifts DEPTH stationary words
// into the chain, then streams weight vectors diagonally skewed across LANES rows.
module is_array_feeder #(
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int LANES        = 4,
  parameter int DEPTH        = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_WIDTH-1:0]          num_vec,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INPUT_WIDTH-1:0]        in_data,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [LANES*WEIGHT_WIDTH-1:0] w_data,
  output logic                          input_en,
  output logic [INPUT_WIDTH-1:0]        input_out,
  output logic [LANES-1:0]              process_en,
  output logic [LANES*WEIGHT_WIDTH-1:0] weight_out,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CNT_WIDTH-1:0] nv_q;
  logic [CNT_WIDTH-1:0] load_cnt;
  logic [CNT_WIDTH-1:0] vec_cnt;
  logic [CNT_WIDTH-1:0] drain_cnt;

  logic in_acc;
  logic w_acc;
  logic load_last;
  logic vec_last;
  logic drain_last;

  assign in_ready = (state == S_LOAD);
  assign w_ready  = (state == S_STREAM);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  assign in_acc     = in_valid & in_ready;
  assign w_acc      = w_valid & w_ready;
  assign load_last  = (load_cnt == CNT_WIDTH'(DEPTH - 1));
  assign vec_last   = (vec_cnt == nv_q - 1'b1);
  assign drain_last = (drain_cnt == CNT_WIDTH'(LANES - 2));

  // NOTE: every branch of a combinational block must assign every output; the
  // default at the top keeps state_next from being inferred as a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_LOAD;
      S_LOAD:   if (in_acc && load_last) state_next = (nv_q != '0) ? S_STREAM : S_DONE;
      S_STREAM: if (w_acc && vec_last) state_next = (LANES > 1) ? S_DRAIN : S_DONE;
      S_DRAIN:  if (drain_last) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      nv_q      <= '0;
      load_cnt  <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        nv_q      <= num_vec;
        load_cnt  <= '0;
        vec_cnt   <= '0;
        drain_cnt <= '0;
      end else begin
        if (in_acc)             load_cnt  <= load_cnt + 1'b1;
        if (w_acc)              vec_cnt   <= vec_cnt + 1'b1;
        if (state == S_DRAIN)   drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

  // Load strobe is registered; input_out holds its last word across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_en  <= 1'b0;
      input_out <= '0;
    end else begin
      input_en <= in_acc;
      if (in_acc) input_out <= in_data;
    end
  end

  // Lane i owns an (i+1)-deep chain; the last stage drives the PE row directly.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WEIGHT_WIDTH-1:0] data_q  [i+1];
    logic                    valid_q [i+1];

    // NOTE: the skew stages are reset, unlike a plain data RAM, because their
    // valid bits drive process_en and must read 0 out of reset or after an abort.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          data_q[k]  <= '0;
          valid_q[k] <= 1'b0;
        end
      end else begin
        data_q[0]  <= w_acc ? w_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
        valid_q[0] <= w_acc;
        for (int k = 1; k <= i; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end

    assign weight_out[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = data_q[i];
    assign process_en[i]                              = valid_q[i];
  end

endmodule
